// File: rtl/aes_axis_out_packer.sv
// Buffers 128-bit AES result blocks in a block FIFO and streams each one as four 32-bit AXIS beats.
// Build option: define AES_OUT_BYTESWAP_EN to byte-reverse every output word at the tdata register.
module aes_axis_out_packer #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int BLK_WIDTH            = 128,
    parameter int FIFO_DEPTH           = 16
) (
    input  logic                              m00_axis_aclk,
    input  logic                              m00_axis_aresetn,
    input  logic                              blk_valid,
    output logic                              blk_ready,
    input  logic [BLK_WIDTH-1:0]              blk_data,
    input  logic                              blk_last,
    output logic                              m00_axis_tvalid,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                              m00_axis_tlast,
    input  logic                              m00_axis_tready,
    output logic                              pkt_done,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);
    localparam int ADDR  = $clog2(FIFO_DEPTH);
    localparam int LVL_W = ADDR + 1;
    localparam int W     = C_M_AXIS_TDATA_WIDTH;
    localparam logic [ADDR:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    // Word 0 is the most significant slice of the block.
    function automatic logic [W-1:0] word_of(input logic [BLK_WIDTH-1:0] b, input logic [1:0] i);
        logic [W-1:0] w;
        case (i)
            2'd0:    w = b[BLK_WIDTH-1 -: W];
            2'd1:    w = b[BLK_WIDTH-1-W -: W];
            2'd2:    w = b[BLK_WIDTH-1-2*W -: W];
            default: w = b[W-1:0];
        endcase
        return w;
    endfunction

    function automatic logic [W-1:0] out_word(input logic [W-1:0] w);
`ifdef AES_OUT_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    logic [BLK_WIDTH:0]   mem [FIFO_DEPTH];
    logic [ADDR-1:0]      wr_ptr, rd_ptr;
    logic [BLK_WIDTH:0]   head;
    logic                 wr_en;

    logic [BLK_WIDTH-1:0] hold_data;
    logic                 hold_last;
    logic [1:0]           word_idx;
    state_t               state, state_nxt;
    logic                 pop, advance;

    assign blk_ready       = (fifo_level != LVL_FULL);
    assign wr_en           = blk_valid && blk_ready;
    assign head            = mem[rd_ptr];
    assign m00_axis_tvalid = (state == SEND);
    assign m00_axis_tstrb  = '1;

    // NOTE: storage array has no reset; entries are only read after being written, so resetting them buys nothing.
    always_ff @(posedge m00_axis_aclk) begin
        if (wr_en) mem[wr_ptr] <= {blk_last, blk_data};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ADDR'(1);
            if (pop)   rd_ptr <= rd_ptr + ADDR'(1);
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) state <= IDLE;
        else                   state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        advance   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (m00_axis_tready) begin
                    if (word_idx != 2'd3)      advance   = 1'b1;
                    else if (fifo_level != '0) pop       = 1'b1;
                    else                       state_nxt = IDLE;
                end
            end
        endcase
    end

    // Output stage: tdata/tlast are registered one word ahead so a pop or advance lands on the next beat.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            hold_data      <= '0;
            hold_last      <= 1'b0;
            word_idx       <= '0;
            m00_axis_tdata <= '0;
            m00_axis_tlast <= 1'b0;
            pkt_done       <= 1'b0;
        end else begin
            pkt_done <= m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;
            if (pop) begin
                hold_data      <= head[BLK_WIDTH-1:0];
                hold_last      <= head[BLK_WIDTH];
                word_idx       <= '0;
                m00_axis_tdata <= out_word(word_of(head[BLK_WIDTH-1:0], 2'd0));
                m00_axis_tlast <= 1'b0;
            end else if (advance) begin
                word_idx       <= word_idx + 2'd1;
                m00_axis_tdata <= out_word(word_of(hold_data, word_idx + 2'd1));
                m00_axis_tlast <= hold_last && (word_idx == 2'd2);
            end else if (state_nxt == IDLE) begin
                m00_axis_tlast <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_axis_out_packer.sv
// Self-checking bench for aes_axis_out_packer: random blocks checked against a word-queue model.
// Honours AES_OUT_BYTESWAP_EN in the model so the same bench covers both builds.
module tb_aes_axis_out_packer;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic         blk_last;
    logic         tvalid;
    logic [31:0]  tdata;
    logic [3:0]   tstrb;
    logic         tlast;
    logic         tready;
    logic         pkt_done;
    logic [2:0]   fifo_level;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    int          tlast_cnt = 0;
    int          pkt_cnt = 0;
    int          hs_run = 0;
    int          hs_run_max = 0;
    logic        prev_hs_last = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always #5 clk = ~clk;

    aes_axis_out_packer #(
        .C_M_AXIS_TDATA_WIDTH(32),
        .BLK_WIDTH(128),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .m00_axis_aclk(clk),
        .m00_axis_aresetn(rst_n),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_data(blk_data),
        .blk_last(blk_last),
        .m00_axis_tvalid(tvalid),
        .m00_axis_tdata(tdata),
        .m00_axis_tstrb(tstrb),
        .m00_axis_tlast(tlast),
        .m00_axis_tready(tready),
        .pkt_done(pkt_done),
        .fifo_level(fifo_level)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: word k of a block is the k-th 32-bit slice counting from the top.
    function automatic logic [31:0] model_word(input logic [127:0] d, input int k);
        logic [31:0] w;
        w = 32'(d >> (32 * (3 - k)));
`ifdef AES_OUT_BYTESWAP_EN
        w = {<<8{w}};
`endif
        return w;
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Output monitor: beat order, AXIS stability, pkt_done timing.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            prev_hs_last = 1'b0;
            prev_stall   = 1'b0;
            hs_run       = 0;
        end else begin
            check("pkt_done", 64'(pkt_done), 64'(prev_hs_last));
            if (pkt_done) pkt_cnt++;
            if (prev_stall) begin
                check("stall_valid", 64'(tvalid), 64'd1);
                check("stall_data", 64'(tdata), 64'(prev_data));
                check("stall_last", 64'(tlast), 64'(prev_last));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", 64'(tdata), 64'(e[31:0]));
                    check("tlast", 64'(tlast), 64'(e[32]));
                end
                if (tlast) tlast_cnt++;
                hs_run++;
                if (hs_run > hs_run_max) hs_run_max = hs_run;
            end else begin
                hs_run = 0;
            end
            prev_hs_last = tvalid && tready && tlast;
            prev_stall   = tvalid && !tready;
            prev_data    = tdata;
            prev_last    = tlast;
        end
    end

    // Call away from a clock edge; returns 1ns after the accepting edge.
    task automatic send_block(input logic [127:0] d, input logic last);
        int n = 0;
        blk_valid = 1'b1;
        blk_data  = d;
        blk_last  = last;
        while (!blk_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!blk_ready) begin
            check("send_timeout", 64'(blk_ready), 64'd1);
        end else begin
            @(posedge clk);
            for (int k = 0; k < 4; k++) exp_q.push_back({last && (k == 3), model_word(d, k)});
            #1;
        end
        blk_valid = 1'b0;
    endtask

    task automatic drain(input bit random_ready);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            if (random_ready) tready = 1'($urandom_range(0, 1));
            n++;
        end
        tready = 1'b1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic latency_block(input logic [127:0] d);
        int p0 = pkt_cnt;
        hs_run_max = 0;
        tready     = 1'b1;
        send_block(d, 1'b1);
        @(negedge clk);
        check("lat_valid_n1", 64'(tvalid), 64'd0);
        check("lat_level_n1", 64'(fifo_level), 64'd1);
        @(negedge clk);
        check("lat_valid_n2", 64'(tvalid), 64'd1);
        check("lat_word0", 64'(tdata), 64'(model_word(d, 0)));
        check("lat_level_n2", 64'(fifo_level), 64'd0);
        drain(1'b0);
        check("single_run", 64'(hs_run_max), 64'd4);
        check("single_pkt", 64'(pkt_cnt - p0), 64'd1);
    endtask

    initial begin
        int p0;
        int t0;
        int n;
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        blk_last  = 1'b0;
        tready    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_pkt_done", 64'(pkt_done), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_blk_ready", 64'(blk_ready), 64'd1);
        check("tstrb", 64'(tstrb), 64'hF);

        // Single block: latency and word order.
        latency_block(128'h00112233_44556677_8899AABB_CCDDEEFF);

        // Three back-to-back blocks form one packet with no bubble.
        t0 = tlast_cnt;
        p0 = pkt_cnt;
        hs_run_max = 0;
        tready = 1'b1;
        for (int b = 0; b < 3; b++) send_block(rand_block(), b == 2);
        drain(1'b0);
        check("b2b_run", 64'(hs_run_max), 64'd12);
        check("b2b_tlast", 64'(tlast_cnt - t0), 64'd1);
        check("b2b_pkt", 64'(pkt_cnt - p0), 64'd1);

        // Backpressure fills the FIFO: five blocks fit, the sixth is refused.
        tready = 1'b0;
        for (int b = 0; b < 5; b++) send_block(rand_block(), b == 4);
        blk_valid = 1'b1;
        blk_data  = rand_block();
        blk_last  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("full_ready", 64'(blk_ready), 64'd0);
            check("full_level", 64'(fifo_level), 64'd4);
        end
        check("full_queue", 64'(exp_q.size()), 64'd20);
        @(posedge clk);
        #1;
        blk_valid  = 1'b0;
        hs_run_max = 0;
        tready     = 1'b1;
        n = 0;
        while (!blk_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reassert_ready", 64'(blk_ready), 64'd1);
        check("reassert_level", 64'(fifo_level), 64'd3);
        drain(1'b0);
        check("full_run", 64'(hs_run_max), 64'd20);

        // Random tready during a two-block packet.
        t0 = tlast_cnt;
        p0 = pkt_cnt;
        tready = 1'b0;
        send_block(rand_block(), 1'b0);
        send_block(rand_block(), 1'b1);
        drain(1'b1);
        check("rand_tlast", 64'(tlast_cnt - t0), 64'd1);
        check("rand_pkt", 64'(pkt_cnt - p0), 64'd1);

        // Reset during the second word of a packet with another block queued.
        tready = 1'b1;
        send_block(rand_block(), 1'b1);
        send_block(rand_block(), 1'b1);
        n = 0;
        while (exp_q.size() != 7 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_queue", 64'(exp_q.size()), 64'd7);
        @(posedge clk);
        #1;
        check("pre_rst_level", 64'(fifo_level), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_tvalid", 64'(tvalid), 64'd0);
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        check("mid_rst_tlast", 64'(tlast), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(blk_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("post_rst_idle", 64'(tvalid), 64'd0);
        t0 = tlast_cnt;
        latency_block(rand_block());
        check("post_rst_tlast", 64'(tlast_cnt - t0), 64'd1);

        // Byte order of the first word is visible directly.
        latency_block(128'h01020304_05060708_090A0B0C_0D0E0F10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
